// File: rtl/ram2b_port_arbiter.sv
// Round-robin arbiter sharing a two-port RAM (two write, two async read ports)
// among NUM_REQ requesters; grants up to two hazard-free accesses per cycle.
module ram2b_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int MEM_SIZE  = 32,
  parameter int ADDR_SIZE = $clog2(MEM_SIZE),
  parameter int NUM_REQ   = 4
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]  i_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]  i_wdata,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic [NUM_REQ*WORD_SIZE-1:0]  o_rdata,
  output logic                          o_write_en_A,
  output logic                          o_write_en_B,
  output logic                          o_read_en_A,
  output logic                          o_read_en_B,
  output logic [ADDR_SIZE-1:0]          o_write_addr_A,
  output logic [ADDR_SIZE-1:0]          o_write_addr_B,
  output logic [ADDR_SIZE-1:0]          o_read_addr_A,
  output logic [ADDR_SIZE-1:0]          o_read_addr_B,
  output logic [WORD_SIZE-1:0]          o_write_data_A,
  output logic [WORD_SIZE-1:0]          o_write_data_B,
  input  logic [WORD_SIZE-1:0]          i_read_data_A,
  input  logic [WORD_SIZE-1:0]          i_read_data_B
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [NUM_REQ-1:0]           rvalid_q, rvalid_d;
  logic [NUM_REQ*WORD_SIZE-1:0] rdata_q, rdata_d;

  logic                 haveA, haveB, weA, weB, skipped;
  logic [PTR_W-1:0]     idxA, idxB, firstSkip, lastIdx;
  logic [ADDR_SIZE-1:0] addrA, addrB;
  logic [WORD_SIZE-1:0] dataA, dataB;
  logic [NUM_REQ-1:0]   gnt;
  int                   scanIdx;
  int                   nextIdx;

  // Circular scan from ptr: first requester takes slot A, the next one that
  // does not collide with slot A takes slot B; colliding ones are skipped.
  always_comb begin
    haveA     = 1'b0;
    haveB     = 1'b0;
    weA       = 1'b0;
    weB       = 1'b0;
    skipped   = 1'b0;
    idxA      = '0;
    idxB      = '0;
    firstSkip = '0;
    addrA     = '0;
    addrB     = '0;
    dataA     = '0;
    dataB     = '0;
    gnt       = '0;
    scanIdx   = 0;
    if (!i_RST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        scanIdx = int'(ptr_q) + i;
        if (scanIdx >= NUM_REQ) scanIdx = scanIdx - NUM_REQ;
        if (i_req[scanIdx]) begin
          if (!haveA) begin
            haveA        = 1'b1;
            idxA         = PTR_W'(scanIdx);
            weA          = i_we[scanIdx];
            addrA        = i_addr[scanIdx*ADDR_SIZE +: ADDR_SIZE];
            dataA        = i_wdata[scanIdx*WORD_SIZE +: WORD_SIZE];
            gnt[scanIdx] = 1'b1;
          end else if (!haveB) begin
            if ((i_addr[scanIdx*ADDR_SIZE +: ADDR_SIZE] == addrA) && (i_we[scanIdx] || weA)) begin
              if (!skipped) begin
                skipped   = 1'b1;
                firstSkip = PTR_W'(scanIdx);
              end
            end else begin
              haveB        = 1'b1;
              idxB         = PTR_W'(scanIdx);
              weB          = i_we[scanIdx];
              addrB        = i_addr[scanIdx*ADDR_SIZE +: ADDR_SIZE];
              dataB        = i_wdata[scanIdx*WORD_SIZE +: WORD_SIZE];
              gnt[scanIdx] = 1'b1;
            end
          end
        end
      end
    end
  end

  // A skipped requester becomes the head of the next scan so it cannot starve.
  always_comb begin
    lastIdx = haveB ? idxB : idxA;
    nextIdx = int'(lastIdx) + 1;
    if (nextIdx >= NUM_REQ) nextIdx = 0;
    ptr_d = ptr_q;
    if (skipped) ptr_d = firstSkip;
    else if (haveA) ptr_d = PTR_W'(nextIdx);
  end

  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (haveA && !weA) begin
      rvalid_d[idxA]                        = 1'b1;
      rdata_d[idxA*WORD_SIZE +: WORD_SIZE]  = i_read_data_A;
    end
    if (haveB && !weB) begin
      rvalid_d[idxB]                        = 1'b1;
      rdata_d[idxB*WORD_SIZE +: WORD_SIZE]  = i_read_data_B;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Masking with reset drops a pulse that was already registered.
  assign o_gnt    = gnt;
  assign o_rvalid = rvalid_q & {NUM_REQ{~i_RST}};
  assign o_rdata  = rdata_q;

  assign o_write_en_A   = haveA & weA;
  assign o_read_en_A    = haveA & ~weA;
  assign o_write_addr_A = (haveA & weA)  ? addrA : '0;
  assign o_read_addr_A  = (haveA & ~weA) ? addrA : '0;
  assign o_write_data_A = (haveA & weA)  ? dataA : '0;

  assign o_write_en_B   = haveB & weB;
  assign o_read_en_B    = haveB & ~weB;
  assign o_write_addr_B = (haveB & weB)  ? addrB : '0;
  assign o_read_addr_B  = (haveB & ~weB) ? addrB : '0;
  assign o_write_data_B = (haveB & weB)  ? dataB : '0;

endmodule

// File: tb/tb_ram2b_port_arbiter.sv
// Bench for ram2b_port_arbiter: directed scenarios plus randomized handshakes,
// all checked against a queue-based reference model and a behavioural RAM.
module tb_ram2b_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int MS = 32;

  logic            i_CLK = 1'b0;
  logic            i_RST;
  logic [N-1:0]    i_req, i_we;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_wdata;
  logic [N-1:0]    o_gnt, o_rvalid;
  logic [N*DW-1:0] o_rdata;
  logic            o_write_en_A, o_write_en_B, o_read_en_A, o_read_en_B;
  logic [AW-1:0]   o_write_addr_A, o_write_addr_B, o_read_addr_A, o_read_addr_B;
  logic [DW-1:0]   o_write_data_A, o_write_data_B;
  logic [DW-1:0]   i_read_data_A, i_read_data_B;

  always #5 i_CLK = ~i_CLK;

  ram2b_port_arbiter #(.WORD_SIZE(DW), .MEM_SIZE(MS), .NUM_REQ(N)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_write_en_A(o_write_en_A), .o_write_en_B(o_write_en_B),
    .o_read_en_A(o_read_en_A), .o_read_en_B(o_read_en_B),
    .o_write_addr_A(o_write_addr_A), .o_write_addr_B(o_write_addr_B),
    .o_read_addr_A(o_read_addr_A), .o_read_addr_B(o_read_addr_B),
    .o_write_data_A(o_write_data_A), .o_write_data_B(o_write_data_B),
    .i_read_data_A(i_read_data_A), .i_read_data_B(i_read_data_B)
  );

  // Behavioural RAM2B: synchronous writes, asynchronous reads.
  logic [DW-1:0] ramArr [MS];
  always @(posedge i_CLK) begin
    if (o_write_en_A) ramArr[o_write_addr_A] <= o_write_data_A;
    if (o_write_en_B) ramArr[o_write_addr_B] <= o_write_data_B;
  end
  assign i_read_data_A = ramArr[o_read_addr_A];
  assign i_read_data_B = ramArr[o_read_addr_B];

  int            totalCount = 0;
  int            badCount   = 0;
  int            mPtr;
  logic [DW-1:0] mMem [MS];
  logic [N*DW-1:0] mRdata;
  logic [N-1:0]  mRvalid, mGnt;
  logic          mHaveA, mHaveB, mSkip;
  int            mA, mB, mFirstSkip;
  logic [N-1:0]  sampledGnt, sampledRvalid;
  logic [27:0]   sampledPortA;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [N*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
    pa = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] pd(input int d0, input int d1, input int d2, input int d3);
    pd = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  // Expected {write_en, read_en, write_addr, read_addr, write_data} for one slot.
  function automatic logic [27:0] expPort(input logic have, input int idx, input logic [N-1:0] we,
                                          input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wdata);
    logic wen, ren;
    wen = have && we[idx];
    ren = have && !we[idx];
    expPort = {wen, ren,
               wen ? addr[idx*AW +: AW] : AW'(0),
               ren ? addr[idx*AW +: AW] : AW'(0),
               wen ? wdata[idx*DW +: DW] : DW'(0)};
  endfunction

  // Reference arbitration: list requesters in rotated order, then pick slots.
  task automatic modelEval(input logic rst, input logic [N-1:0] req, input logic [N-1:0] we,
                           input logic [N*AW-1:0] addr);
    int order[$];
    mGnt = '0; mHaveA = 0; mHaveB = 0; mSkip = 0; mA = 0; mB = 0; mFirstSkip = 0;
    if (rst) return;
    for (int i = 0; i < N; i++)
      if (req[(mPtr + i) % N]) order.push_back((mPtr + i) % N);
    if (order.size() == 0) return;
    mHaveA = 1; mA = order[0]; mGnt[mA] = 1'b1;
    for (int j = 1; j < order.size(); j++) begin
      if (addr[order[j]*AW +: AW] == addr[mA*AW +: AW] && (we[order[j]] || we[mA])) begin
        if (!mSkip) begin mSkip = 1; mFirstSkip = order[j]; end
      end else begin
        mHaveB = 1; mB = order[j]; mGnt[mB] = 1'b1;
        break;
      end
    end
  endtask

  task automatic modelCommit(input logic rst, input logic [N-1:0] we, input logic [N*AW-1:0] addr,
                             input logic [N*DW-1:0] wdata);
    if (rst) begin
      mPtr = 0; mRdata = '0; mRvalid = '0;
      return;
    end
    mRvalid = '0;
    if (mHaveA && !we[mA]) begin mRdata[mA*DW +: DW] = mMem[addr[mA*AW +: AW]]; mRvalid[mA] = 1'b1; end
    if (mHaveB && !we[mB]) begin mRdata[mB*DW +: DW] = mMem[addr[mB*AW +: AW]]; mRvalid[mB] = 1'b1; end
    if (mHaveA && we[mA]) mMem[addr[mA*AW +: AW]] = wdata[mA*DW +: DW];
    if (mHaveB && we[mB]) mMem[addr[mB*AW +: AW]] = wdata[mB*DW +: DW];
    if (mSkip) mPtr = mFirstSkip;
    else if (mHaveA) mPtr = ((mHaveB ? mB : mA) + 1) % N;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registers.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] req, input logic [N-1:0] we,
                               input logic [N*AW-1:0] addr, input logic [N*DW-1:0] wdata);
    i_RST = rst; i_req = req; i_we = we; i_addr = addr; i_wdata = wdata;
    #2;
    modelEval(rst, req, we, addr);
    sampledGnt    = o_gnt;
    sampledRvalid = o_rvalid;
    sampledPortA  = {o_write_en_A, o_read_en_A, o_write_addr_A, o_read_addr_A, o_write_data_A};
    checkOutput("gnt", o_gnt, mGnt);
    checkOutput("portA", sampledPortA, expPort(mHaveA, mA, we, addr, wdata));
    checkOutput("portB", {o_write_en_B, o_read_en_B, o_write_addr_B, o_read_addr_B, o_write_data_B},
                expPort(mHaveB, mB, we, addr, wdata));
    checkOutput("rvalid_pre", o_rvalid, rst ? '0 : mRvalid);
    @(posedge i_CLK);
    modelCommit(rst, we, addr, wdata);
    #1;
    checkOutput("rdata", o_rdata, mRdata);
    checkOutput("rvalid", o_rvalid, rst ? '0 : mRvalid);
  endtask

  logic [N-1:0]  pend, pWe;
  logic [AW-1:0] pAddr [N];
  logic [DW-1:0] pData [N];
  int            waitCnt [N];
  logic [N*AW-1:0] vAddr;
  logic [N*DW-1:0] vData;
  logic          rRst;

  initial begin
    for (int a = 0; a < MS; a++) begin ramArr[a] = '0; mMem[a] = '0; end
    mPtr = 0; mRdata = '0; mRvalid = '0;
    i_RST = 1'b1; i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0;
    @(posedge i_CLK); #1;

    applyStimulus(1'b1, 4'hF, 4'h0, pa(0, 1, 2, 3), '0);
    applyStimulus(1'b1, 4'hF, 4'h0, pa(0, 1, 2, 3), '0);
    checkOutput("rst_gnt", sampledGnt, 4'b0000);
    checkOutput("rst_rdata", o_rdata, '0);

    applyStimulus(1'b0, 4'hF, 4'h0, pa(10, 11, 12, 13), '0);
    checkOutput("first_gnt", sampledGnt, 4'b0011);
    checkOutput("first_slotA", sampledPortA, {1'b0, 1'b1, 5'd0, 5'd10, 16'h0});

    applyStimulus(1'b0, 4'b0011, 4'b0011, pa(3, 7, 0, 0), pd('hBEEF, 'h1234, 0, 0));
    checkOutput("ww_both_gnt", sampledGnt, 4'b0011);
    applyStimulus(1'b0, 4'b0011, 4'b0000, pa(3, 7, 0, 0), '0);
    checkOutput("rr_rvalid", o_rvalid, 4'b0011);
    checkOutput("rr_rdata0", o_rdata[15:0], 16'hBEEF);
    checkOutput("rr_rdata1", o_rdata[31:16], 16'h1234);

    applyStimulus(1'b0, 4'b0001, 4'b0000, pa(20, 0, 0, 0), '0);
    applyStimulus(1'b0, 4'b0110, 4'b0110, pa(0, 5, 5, 0), pd(0, 'h1111, 'h2222, 0));
    checkOutput("wwh_gnt", sampledGnt, 4'b0010);
    applyStimulus(1'b0, 4'b0100, 4'b0100, pa(0, 0, 5, 0), pd(0, 0, 'h2222, 0));
    checkOutput("wwh_gnt2", sampledGnt, 4'b0100);
    checkOutput("wwh_ram5", ramArr[5], 16'h2222);

    applyStimulus(1'b0, 4'b0011, 4'b0001, pa(9, 9, 0, 0), pd('h00AA, 0, 0, 0));
    checkOutput("rwh_gnt", sampledGnt, 4'b0001);
    applyStimulus(1'b0, 4'b0010, 4'b0000, pa(0, 9, 0, 0), '0);
    checkOutput("rwh_gnt2", sampledGnt, 4'b0010);
    checkOutput("rwh_rdata1", o_rdata[31:16], 16'h00AA);

    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 4'hF, 4'h0, pa(16, 17, 18, 19), '0);
      checkOutput("fair_gnt", sampledGnt, (c % 2 == 0) ? 4'b1100 : 4'b0011);
      checkOutput("fair_rvalid", o_rvalid, (c % 2 == 0) ? 4'b1100 : 4'b0011);
    end

    applyStimulus(1'b0, 4'b1000, 4'b0000, pa(0, 0, 0, 21), '0);
    checkOutput("mid_gnt3", sampledGnt, 4'b1000);
    applyStimulus(1'b1, 4'b1000, 4'b0000, pa(0, 0, 0, 21), '0);
    checkOutput("mid_rvalid3", sampledRvalid[3], 1'b0);
    checkOutput("mid_rdata", o_rdata, '0);
    applyStimulus(1'b0, 4'hF, 4'h0, pa(1, 2, 3, 4), '0);
    checkOutput("mid_ptr0", sampledGnt, 4'b0011);

    pend = '0; pWe = '0;
    for (int k = 0; k < N; k++) begin pAddr[k] = '0; pData[k] = '0; waitCnt[k] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 3) != 0) begin
          pend[k]    = 1'b1;
          pWe[k]     = 1'($urandom_range(0, 1));
          pAddr[k]   = AW'($urandom_range(0, 7));
          pData[k]   = DW'($urandom);
          waitCnt[k] = 0;
        end
        vAddr[k*AW +: AW] = pAddr[k];
        vData[k*DW +: DW] = pData[k];
      end
      rRst = ($urandom_range(0, 49) == 0);
      applyStimulus(rRst, pend, pWe, vAddr, vData);
      for (int k = 0; k < N; k++) begin
        if (rRst) waitCnt[k] = 0;
        else if (pend[k]) begin
          if (mGnt[k]) pend[k] = 1'b0;
          else begin
            waitCnt[k]++;
            if (waitCnt[k] >= N) checkOutput("starve", waitCnt[k], N - 1);
          end
        end
      end
    end

    for (int a = 0; a < 8; a++) checkOutput("ram_final", ramArr[a], mMem[a]);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/ram2b_port_arbiter.md
# ram2b_port_arbiter

Round-robin arbiter that shares the two-port block RAM (RAM2B: two write ports, two asynchronous read ports) among `NUM_REQ` pipeline requesters, such as fetch, load/store and loader.
- Each cycle it grants up to two requests: one on slot A and one on slot B.
- It blocks same-cycle address hazards.
- It registers read data back to each requester with a one-cycle valid pulse.
- It sits between the pipeline stages and the RAM instance and is the only driver of the RAM's enable, address and data inputs.

## Interface
- `WORD_SIZE`, 16, data word width.
- `MEM_SIZE`, 32, RAM depth in words.
- `ADDR_SIZE`, `$clog2(MEM_SIZE)`, address width.
- `NUM_REQ`, 4, number of requesters (2..8).
- `i_CLK` in 1: single clock, rising edge.
- `i_RST` in 1: reset, synchronous, active-high.
- `i_req` in `NUM_REQ`: request per requester.
- `i_we` in `NUM_REQ`: 1 = write, 0 = read.
- `i_addr` in `NUM_REQ*ADDR_SIZE`: packed addresses; requester k occupies bits `[k*ADDR_SIZE +: ADDR_SIZE]`.
- `i_wdata` in `NUM_REQ*WORD_SIZE`: packed write data, same packing.
- `o_gnt` out `NUM_REQ`: combinational grant.
- `o_rvalid` out `NUM_REQ`: read data valid, one-cycle pulse.
- `o_rdata` out `NUM_REQ*WORD_SIZE`: registered read data per requester.
- `o_write_en_A`, `o_write_en_B`, `o_read_en_A`, `o_read_en_B` out 1: RAM enables.
- `o_write_addr_A/B`, `o_read_addr_A/B` out `ADDR_SIZE`: RAM addresses.
- `o_write_data_A/B` out `WORD_SIZE`: RAM write data.
- `i_read_data_A/B` in `WORD_SIZE`: RAM asynchronous read data.

## Operation
- Round-robin pointer `ptr`, `$clog2(NUM_REQ)` bits, reset value 0.
- **Candidate scan:** requesters with `i_req=1` are scanned in circular order starting at `ptr`.
  - The first candidate goes to slot A.
  - The next eligible candidate goes to slot B.
- **Slot B eligibility:** a candidate is ineligible for slot B if its address equals slot A's address and either access is a write.
  - This covers write/write, write/read and read/write conflicts.
  - An ineligible candidate is *skipped*: not granted this cycle. The scan continues past it.
  - Two reads to the same address are both granted.
- **Slot to RAM port mapping:**
  - A write in slot A drives `o_write_en_A`, `o_write_addr_A` and `o_write_data_A`.
  - A read in slot A drives `o_read_en_A` and `o_read_addr_A`.
  - Slot B maps the same way to the B ports.
  - At most one enable per slot is high.
  - Unused RAM address and data outputs are driven to 0.
- **Pointer update at each posedge:**
  - If a candidate was skipped, `ptr` takes the index of the first skipped requester. This prevents starvation.
  - Otherwise, if at least one grant occurred, `ptr` takes (index of last granted + 1) mod `NUM_REQ`.
  - With no grants, `ptr` is unchanged.
- **Request handshake:** requester k holds `i_req`, `i_we`, `i_addr` and `i_wdata` stable until it samples `o_gnt[k]=1` at a rising edge. The transfer completes at that edge.
- **Write commit:** the write is performed by the RAM at the grant edge.
- **Read capture:** at the grant edge, the slot's `i_read_data` is captured into `o_rdata[k]`, and `o_rvalid[k]` is set for the following cycle only.
- **Read data hold:** `o_rdata[k]` holds its value until the next read grant to k.
- **Fairness bound:** a continuously requesting requester is granted within `NUM_REQ` cycles.

## Timing
- Grant latency: 0 cycles. `o_gnt` is combinational from `i_req`, `i_we`, `i_addr` and `ptr`.
- Read latency: `o_rvalid[k]` and `o_rdata[k]` become valid the cycle after the grant edge.
- Write visibility: a read granted in the cycle after a write returns the new data.
- Throughput: 2 accesses/cycle when no hazards exist.
- Back-to-back reads by the same requester give one `o_rvalid` pulse per grant, on consecutive cycles.
- While `i_RST=1`:
  - `o_gnt`, `o_rvalid`, all RAM enables, RAM addresses and RAM data outputs are 0.
  - `o_rdata` and `ptr` are cleared to 0 at the edge.
- Reset mid-operation: a pending `o_rvalid` pulse is dropped. No RAM write occurs in any cycle with `i_RST=1`.
- Deasserting `i_req` without a grant is legal; the request is withdrawn.

## Test plan
- **Reset:** assert `i_RST` for 2 cycles with all `i_req=1` -> `o_gnt=0`, all RAM enables 0, `o_rvalid=0`, `o_rdata=0`; the first grant after release goes to requester 0 on slot A.
- **Two writes then two reads:** req0 writes 0xBEEF@3 and req1 writes 0x1234@7 in the same cycle -> both granted. The next cycle req0 reads @3 and req1 reads @7 -> one cycle later `o_rvalid=4'b0011` with rdata 0xBEEF and 0x1234.
- **Write/write hazard:** req1 and req2 both write address 5, `ptr=1` -> only req1 granted, `ptr` becomes 2, req2 granted next cycle, final RAM[5] = req2 data.
- **Read/write hazard:** req0 writes 0x00AA@9 while req1 reads @9 -> req1 skipped, then granted next cycle, and returns 0x00AA.
- **Fairness:** all four requesters read continuously at distinct addresses -> grant pairs {0,1},{2,3},{0,1}... Every requester gets one `o_rvalid` pulse per 2 cycles.
- **Mid-operation reset:** req3 read granted, `i_RST` asserted on the next cycle -> `o_rvalid[3]` stays 0, `o_rdata` cleared, `ptr=0`.
